seg7_capture_8: RTL and testbench
=================================

SEG7_CAPTURE_8 -- requirements
Module: seg7_capture_8

Interface
REQ-001 Parameter STABLE_CNT, default 3: consecutive identical synchronized samples required to capture a digit; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 65535: idle cycles without any capture before a partial frame is discarded; 16-bit counter.
REQ-003 iCLK  in  1  sole clock; all state on rising edge.
REQ-004 iRST  in  1  reset, asynchronous, active-high.
REQ-005 iSEG  in  7  segment lines of a multiplexed display, active-low (0 = lit); bit0 = a ... bit6 = g; asynchronous to iCLK.
REQ-006 iDIG_SEL  in  8  digit select, active-high, one-hot expected; bit k selects digit k; asynchronous to iCLK.
REQ-007 oDIG  out  32  last complete decoded frame; digit k in [4k+3:4k].
REQ-008 oERR  out  8  per-digit flag for the last frame: bit k = 1 means digit k's pattern was not a legal hex glyph.
REQ-009 oVALID  out  1  single-cycle pulse marking an oDIG/oERR update.
REQ-010 oSTALE  out  1  level: set on timeout, cleared on the next oVALID.

Function
REQ-011 iSEG and iDIG_SEL SHALL each pass through a 2-flop synchronizer; all further logic uses only the synchronized values (sSEG, sSEL).
REQ-012 The stability counter SHALL increment while {sSEL, sSEG} equals its previous-cycle value, saturating, and reset to 1 on any change.
REQ-013 A capture SHALL occur on the edge where the counter reaches STABLE_CNT with sSEL one-hot; only one capture per run; a new run requires a change of {sSEL, sSEG}.
REQ-014 If sSEL is zero or multi-hot, no capture SHALL occur, and the run still counts for re-arming.
REQ-015 Capture decode, pattern in hex (bit6..bit0) -> nibble: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
REQ-016 Any other pattern SHALL decode to nibble 0 with that digit's shadow error bit set; a legal pattern clears it.
REQ-017 A capture SHALL write the nibble and error bit into shadow slot k and set capture-mask bit k; recapture of an already-set slot overwrites it (latest wins).
REQ-018 On the edge where a capture leaves all 8 mask bits set, the block SHALL, on that same edge: load oDIG from the shadow (including the new nibble), load oERR, pulse oVALID high for exactly one cycle, clear oSTALE, and clear the mask.
REQ-019 oDIG and oERR SHALL hold their values between oVALID pulses.
REQ-020 The idle counter SHALL reset on every capture and increment otherwise, saturating at TIMEOUT.
REQ-021 On reaching TIMEOUT, the block SHALL clear the mask (discarding the partial frame) and set oSTALE; oDIG and oERR are unchanged.
REQ-022 A timeout coinciding with a capture SHALL be ignored; the capture takes precedence.
REQ-023 Minimum latency from a stable input change to capture SHALL be 2 + STABLE_CNT cycles.

Reset
REQ-024 While iRST is asserted: oDIG = 0, oERR = 0, oVALID = 0, oSTALE = 0, and all synchronizers, shadow, mask and counters are 0.
REQ-025 Reset asserted mid-frame SHALL discard all partial captures; after release, the first oVALID requires 8 fresh captures.
REQ-026 Reset deassertion SHALL take effect at the first iCLK edge after release; no output may change asynchronously except toward its reset value.

Verification
REQ-027 Scan digits 0..7 with glyphs 1..8 (79,24,30,19,12,02,78,00), 8 cycles each -> one oVALID, oDIG = 32'h87654321, oERR = 0.
REQ-028 Digit 3 holds pattern 7F (blank) -> oERR = 8'h08 and oDIG[15:12] = 0; all other nibbles correct.
REQ-029 STABLE_CNT = 3; digit 2 is held only 2 synchronized cycles within an otherwise valid scan -> no capture for digit 2 and no oVALID for that scan.
REQ-030 Multi-hot select 8'h03 held 20 cycles -> no mask change; the scan then completes normally.
REQ-031 TIMEOUT = 100; capture 5 digits, then idle 100 cycles -> oSTALE = 1, mask cleared; a following full scan -> oVALID, oSTALE = 0.
REQ-032 iRST pulsed after 6 captures -> all outputs 0; the next 2 digits alone produce no oVALID.

Source files
------------

// File: rtl/seg7_capture_8.sv
// seg7_capture_8: samples a multiplexed, active-low 7-segment display and
// rebuilds the 8-digit hex value that it shows.
// Segment and select lines are synchronized first. A digit is captured
// after its pattern has been stable for STABLE_CNT cycles. A complete frame
// of 8 captured digits updates oDIG/oERR and pulses oVALID.
// A partial frame with no capture for TIMEOUT cycles is dropped and oSTALE is set.
module seg7_capture_8 #(
   parameter int STABLE_CNT = 3,
   parameter int TIMEOUT    = 65535
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic [6:0]  iSEG,
   input  logic [7:0]  iDIG_SEL,
   output logic [31:0] oDIG,
   output logic [7:0]  oERR,
   output logic        oVALID,
   output logic        oSTALE
);

   localparam logic [3:0]  STB_CNT = 4'(STABLE_CNT);
   localparam logic [15:0] TO_CNT  = 16'(TIMEOUT);

   // Returns {err, nibble}. A pattern that is not a hex glyph gives nibble 0 with err set.
   function automatic logic [4:0] decode(input logic [6:0] pat);
      logic [4:0] r;
      case (pat)
         7'h40:   r = 5'h00;
         7'h79:   r = 5'h01;
         7'h24:   r = 5'h02;
         7'h30:   r = 5'h03;
         7'h19:   r = 5'h04;
         7'h12:   r = 5'h05;
         7'h02:   r = 5'h06;
         7'h78:   r = 5'h07;
         7'h00:   r = 5'h08;
         7'h18:   r = 5'h09;
         7'h08:   r = 5'h0A;
         7'h03:   r = 5'h0B;
         7'h46:   r = 5'h0C;
         7'h21:   r = 5'h0D;
         7'h06:   r = 5'h0E;
         7'h0E:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

   logic [6:0]  seg_s1_q, seg_s2_q;
   logic [7:0]  sel_s1_q, sel_s2_q;
   logic [14:0] prev_q,  prev_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic        done_q,  done_d;
   logic [31:0] shd_nib_q, shd_nib_d;
   logic [7:0]  shd_err_q, shd_err_d;
   logic [7:0]  mask_q,  mask_d;
   logic [15:0] idle_q,  idle_d;
   logic [31:0] dig_q,   dig_d;
   logic [7:0]  err_q,   err_d;
   logic        valid_q, valid_d;
   logic        stale_q, stale_d;

   logic [14:0] cur;
   logic        chg;
   logic        reach;
   logic        sel_onehot;
   logic        cap;
   logic [4:0]  dec;
   logic [7:0]  mask_new;

   // Two-flop synchronizers for the asynchronous display lines.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         seg_s1_q <= '0;
         seg_s2_q <= '0;
         sel_s1_q <= '0;
         sel_s2_q <= '0;
      end else begin
         seg_s1_q <= iSEG;
         seg_s2_q <= seg_s1_q;
         sel_s1_q <= iDIG_SEL;
         sel_s2_q <= sel_s1_q;
      end
   end

   // Stability run tracking. done marks that this run already hit STABLE_CNT,
   // so a run captures at most once, even when STABLE_CNT equals the saturation value.
   always_comb begin
      cur        = {sel_s2_q, seg_s2_q};
      chg        = (cur != prev_q);
      prev_d     = cur;
      cnt_d      = chg ? 4'd1 : ((cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1);
      reach      = (cnt_d == STB_CNT) && (chg || !done_q);
      done_d     = chg ? reach : (done_q | reach);
      sel_onehot = (sel_s2_q != 8'd0) && ((sel_s2_q & (sel_s2_q - 8'd1)) == 8'd0);
      cap        = reach && sel_onehot;
      dec        = decode(seg_s2_q);
   end

   // Shadow frame, capture mask, idle timer and output registers.
   // A capture outranks a timeout on the same edge.
   always_comb begin
      shd_nib_d = shd_nib_q;
      shd_err_d = shd_err_q;
      mask_d    = mask_q;
      idle_d    = idle_q;
      dig_d     = dig_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      stale_d   = stale_q;
      mask_new  = mask_q | sel_s2_q;
      if (cap) begin
         for (int k = 0; k < 8; k++) begin
            if (sel_s2_q[k]) begin
               shd_nib_d[4*k +: 4] = dec[3:0];
               shd_err_d[k]        = dec[4];
            end
         end
         idle_d = '0;
         if (mask_new == 8'hFF) begin
            dig_d   = shd_nib_d;
            err_d   = shd_err_d;
            valid_d = 1'b1;
            stale_d = 1'b0;
            mask_d  = '0;
         end else begin
            mask_d = mask_new;
         end
      end else if (idle_q != TO_CNT) begin
         idle_d = idle_q + 16'd1;
         if (idle_d == TO_CNT) begin
            mask_d  = '0;
            stale_d = 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         prev_q    <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         shd_nib_q <= '0;
         shd_err_q <= '0;
         mask_q    <= '0;
         idle_q    <= '0;
         dig_q     <= '0;
         err_q     <= '0;
         valid_q   <= 1'b0;
         stale_q   <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         shd_nib_q <= shd_nib_d;
         shd_err_q <= shd_err_d;
         mask_q    <= mask_d;
         idle_q    <= idle_d;
         dig_q     <= dig_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         stale_q   <= stale_d;
      end
   end

   assign oDIG   = dig_q;
   assign oERR   = err_q;
   assign oVALID = valid_q;
   assign oSTALE = stale_q;

endmodule

// File: tb/tb_seg7_capture_8.sv
// Directed bench for seg7_capture_8 (STABLE_CNT=3, TIMEOUT=100).
module tb_seg7_capture_8;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg;
   logic [7:0]  sel;
   logic [31:0] dig;
   logic [7:0]  err;
   logic        valid;
   logic        stale;

   int n_checks = 0;
   int n_errors = 0;
   int vcount   = 0;
   int vbase;

   // digit0..7 show 1..8
   localparam logic [55:0] G_STD = {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
   // digit0..7 show C,d,E,F,0,6,7,8
   localparam logic [55:0] G_B   = {7'h00, 7'h78, 7'h02, 7'h40, 7'h0E, 7'h06, 7'h21, 7'h46};

   seg7_capture_8 #(.STABLE_CNT(3), .TIMEOUT(100)) dut (
      .iCLK    (clk),
      .iRST    (rst),
      .iSEG    (seg),
      .iDIG_SEL(sel),
      .oDIG    (dig),
      .oERR    (err),
      .oVALID  (valid),
      .oSTALE  (stale)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (valid) vcount++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] s, input logic [6:0] g, input int n);
      sel = s;
      seg = g;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input logic [55:0] gl, input logic [7:0] which);
      for (int k = 0; k < 8; k++)
         if (which[k]) drive(8'(1 << k), gl[7*k +: 7], 8);
   endtask

   initial begin
      rst = 1'b1;
      seg = 7'h7F;
      sel = 8'h00;
      #12;
      check("rst_dig",   dig,   32'h0);
      check("rst_err",   {24'h0, err}, 32'h0);
      check("rst_valid", {31'h0, valid}, 32'h0);
      check("rst_stale", {31'h0, stale}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(8'h00, 7'h7F, 3);

      // full scan of 1..8
      vbase = vcount;
      scan(G_STD, 8'hFF);
      check("scan1_vcount", 32'(vcount - vbase), 32'd1);
      check("scan1_dig",    dig, 32'h87654321);
      check("scan1_err",    {24'h0, err}, 32'h0);
      check("scan1_stale",  {31'h0, stale}, 32'h0);

      // digit 3 blank
      vbase = vcount;
      scan(G_STD, 8'h07);
      drive(8'h08, 7'h7F, 8);
      scan(G_STD, 8'hF0);
      check("blank_vcount", 32'(vcount - vbase), 32'd1);
      check("blank_dig",    dig, 32'h87650321);
      check("blank_err",    {24'h0, err}, 32'h08);

      // digit 2 held only 2 cycles: no capture, no frame
      vbase = vcount;
      scan(G_STD, 8'h03);
      drive(8'h04, 7'h30, 2);
      scan(G_STD, 8'hF8);
      check("short_vcount", 32'(vcount - vbase), 32'd0);
      check("short_dig_hold", dig, 32'h87650321);
      // digit 2 alone completes the frame; also checks 2+STABLE_CNT latency
      sel = 8'h04;
      seg = 7'h08;
      repeat (4) @(negedge clk);
      check("lat_before", {31'h0, valid}, 32'h0);
      @(negedge clk);
      check("lat_at",     {31'h0, valid}, 32'h1);
      repeat (3) @(negedge clk);
      check("short_dig", dig, 32'h87654A21);
      check("short_err", {24'h0, err}, 32'h0);
      check("short_vcount2", 32'(vcount - vbase), 32'd1);

      // multi-hot select must not touch the mask
      vbase = vcount;
      drive(8'h03, 7'h79, 20);
      scan(G_STD, 8'hFC);
      check("multi_vcount", 32'(vcount - vbase), 32'd0);
      scan(G_STD, 8'h03);
      check("multi_vcount2", 32'(vcount - vbase), 32'd1);
      check("multi_dig", dig, 32'h87654321);

      // timeout on a partial frame
      vbase = vcount;
      scan(G_B, 8'h1F);
      drive(8'h00, 7'h7F, 90);
      check("to_early_stale", {31'h0, stale}, 32'h0);
      drive(8'h00, 7'h7F, 15);
      check("to_stale",  {31'h0, stale}, 32'h1);
      check("to_dig",    dig, 32'h87654321);
      check("to_vcount", 32'(vcount - vbase), 32'd0);
      scan(G_B, 8'hE0);
      check("to_partial_vcount", 32'(vcount - vbase), 32'd0);
      check("to_partial_stale",  {31'h0, stale}, 32'h1);
      scan(G_B, 8'h1F);
      check("to_full_vcount", 32'(vcount - vbase), 32'd1);
      check("to_full_dig",    dig, 32'h8760FEDC);
      check("to_full_stale",  {31'h0, stale}, 32'h0);

      // reset mid-frame
      scan(G_STD, 8'h3F);
      rst = 1'b1;
      sel = 8'h00;
      #1;
      check("mid_rst_dig",   dig, 32'h0);
      check("mid_rst_err",   {24'h0, err}, 32'h0);
      check("mid_rst_valid", {31'h0, valid}, 32'h0);
      check("mid_rst_stale", {31'h0, stale}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      vbase = vcount;
      scan(G_STD, 8'hC0);
      check("post_rst_vcount", 32'(vcount - vbase), 32'd0);
      check("post_rst_dig",    dig, 32'h0);
      scan(G_STD, 8'hFF);
      check("post_rst_vcount2", 32'(vcount - vbase), 32'd1);
      check("post_rst_dig2",    dig, 32'h87654321);

      drive(8'h00, 7'h7F, 2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
